hex_scan_display: RTL



---
 rtl/hex_scan_display_if.sv | 25 ++
 rtl/hex_scan_display.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_scan_display_if.sv
// Bundle of the display driver's data/strobe inputs and its pin-level outputs.
// The master side (score/timer logic) drives digits and load; the slave side
// (the scan driver) drives the seg/dp/an pins and the frame pulse.
interface hex_scan_display_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    load;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (
      output value, dp_in, digit_en, load,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, dp_in, digit_en, load,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex driver for a common-anode 7-segment display.
// One digit is lit per REFRESH_DIV clocks, round-robin from digit 0.
// New values are captured into a pending buffer on load and only become
// visible at the frame boundary, so a frame never shows a mix of old and new.
module hex_scan_display #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1
) (
   input  logic              clk,
   input  logic              rst,
   hex_scan_display_if.slave bus
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0:    seg_decode = 7'h40;
         4'h1:    seg_decode = 7'h79;
         4'h2:    seg_decode = 7'h24;
         4'h3:    seg_decode = 7'h30;
         4'h4:    seg_decode = 7'h19;
         4'h5:    seg_decode = 7'h12;
         4'h6:    seg_decode = 7'h02;
         4'h7:    seg_decode = 7'h78;
         4'h8:    seg_decode = 7'h00;
         4'h9:    seg_decode = 7'h18;
         4'hA:    seg_decode = 7'h08;
         4'hB:    seg_decode = 7'h03;
         4'hC:    seg_decode = 7'h46;
         4'hD:    seg_decode = 7'h21;
         4'hE:    seg_decode = 7'h06;
         4'hF:    seg_decode = 7'h0E;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   logic [DIV_W-1:0]        div_cnt_r;
   logic [IDX_W-1:0]        digit_idx_r;
   logic [4*NUM_DIGITS-1:0] pending_val_r;
   logic [NUM_DIGITS-1:0]   pending_dp_r;
   logic                    pend_valid_r;
   logic [4*NUM_DIGITS-1:0] active_val_r;
   logic [NUM_DIGITS-1:0]   active_dp_r;
   logic [6:0]              seg_r;
   logic                    dp_r;
   logic [NUM_DIGITS-1:0]   an_r;
   logic                    frame_done_r;

   logic                    tick_s;
   logic                    wrap_s;
   logic [NUM_DIGITS-1:0]   sel_s;
   logic [3:0]              cur_nib_s;
   logic                    cur_dp_s;
   logic                    cur_en_s;
   logic                    cur_lz_s;
   logic                    blank_s;

   // Terminal count of the dwell counter, and the frame wrap on the last digit.
   always_comb begin
      tick_s = (div_cnt_r == DIV_LAST);
      wrap_s = tick_s && (digit_idx_r == IDX_LAST);
   end

   // Select the current digit's nibble/dp/enable and decide whether it is blanked.
   // Leading-zero detection walks from the top digit down, tracking whether
   // every nibble at or above the current position is zero.
   always_comb begin
      logic run_zero_v;
      run_zero_v = 1'b1;
      sel_s      = {NUM_DIGITS{1'b0}};
      cur_nib_s  = 4'h0;
      cur_dp_s   = 1'b0;
      cur_en_s   = 1'b0;
      cur_lz_s   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero_v = run_zero_v & (active_val_r[4*i +: 4] == 4'h0);
         sel_s[i]   = (digit_idx_r == IDX_W'(i));
         cur_nib_s  = cur_nib_s | (active_val_r[4*i +: 4] & {4{sel_s[i]}});
         cur_dp_s   = cur_dp_s | (active_dp_r[i] & sel_s[i]);
         cur_en_s   = cur_en_s | (bus.digit_en[i] & sel_s[i]);
         cur_lz_s   = cur_lz_s | (sel_s[i] & run_zero_v & ~active_dp_r[i] &
                                  (i > 0) & (BLANK_LEADING != 0));
      end
      blank_s = ~cur_en_s | cur_lz_s;
   end

   // Dwell counter and round-robin digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r   <= {DIV_W{1'b0}};
         digit_idx_r <= {IDX_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r   <= {DIV_W{1'b0}};
         digit_idx_r <= wrap_s ? {IDX_W{1'b0}} : digit_idx_r + IDX_W'(1);
      end else begin
         div_cnt_r   <= div_cnt_r + DIV_W'(1);
      end
   end

   // Pending capture on load; pending moves to active only at the frame wrap.
   // A load on the wrap cycle lets the older pending commit and re-arms with the new one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_val_r <= {(4*NUM_DIGITS){1'b0}};
         pending_dp_r  <= {NUM_DIGITS{1'b0}};
         pend_valid_r  <= 1'b0;
         active_val_r  <= {(4*NUM_DIGITS){1'b0}};
         active_dp_r   <= {NUM_DIGITS{1'b0}};
      end else begin
         if (wrap_s && pend_valid_r) begin
            active_val_r <= pending_val_r;
            active_dp_r  <= pending_dp_r;
         end
         if (bus.load) begin
            pending_val_r <= bus.value;
            pending_dp_r  <= bus.dp_in;
            pend_valid_r  <= 1'b1;
         end else if (wrap_s) begin
            pend_valid_r  <= 1'b0;
         end
      end
   end

   // Registered pin drivers, one cycle behind the digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r        <= 7'h7F;
         dp_r         <= 1'b1;
         an_r         <= {NUM_DIGITS{1'b1}};
         frame_done_r <= 1'b0;
      end else begin
         seg_r        <= blank_s ? 7'h7F : seg_decode(cur_nib_s);
         dp_r         <= blank_s | ~cur_dp_s;
         an_r         <= ~sel_s;
         frame_done_r <= wrap_s;
      end
   end

   assign bus.seg        = seg_r;
   assign bus.dp         = dp_r;
   assign bus.an         = an_r;
   assign bus.frame_done = frame_done_r;

endmodule
